// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: instruction fetch and issue stage.
// Issues one fetch per cycle into a fixed 1-cycle-latency instruction
// memory and queues the returned words with their PCs in a small FIFO.
// The FIFO head is presented to decode under a valid/ready handshake.
// Redirect flushes everything and restarts fetch. An undefined opcode
// (010/011) halts fetching until the next redirect.
module fetch_issue_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    output logic                         imem_en,
    output logic [PC_WIDTH-1:0]          imem_addr,
    input  logic [INSTR_WIDTH-1:0]       imem_rdata,
    output logic                         issue_valid,
    output logic [INSTR_WIDTH-1:0]       issue_instr,
    output logic [2:0]                   issue_opcode,
    output logic [PC_WIDTH-1:0]          issue_pc,
    output logic                         issue_illegal,
    input  logic                         issue_ready,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    output logic                         halted,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PC_WIDTH-1:0] PC_ONE  = 1;
    localparam logic [AW-1:0]       PTR_ONE = 1;
    localparam logic [CW-1:0]       CNT_ONE = 1;
    localparam logic [CW:0]         DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {RUN, HALTED} state_t;

    state_t state_q, state_d;

    logic [PC_WIDTH-1:0]                   pc_q;
    logic                                  pending_q;
    logic [PC_WIDTH-1:0]                   pending_pc_q;
    logic [AW-1:0]                         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                         count_q;
    logic [DEPTH-1:0][INSTR_WIDTH-1:0]     fifo_instr;
    logic [DEPTH-1:0][PC_WIDTH-1:0]        fifo_pc;

    logic          push, pop;
    logic          rdata_illegal;
    logic [CW:0]   credit_used;

    // Outstanding slots: queued words plus the one in flight. Slots are
    // only reclaimed once a pop has actually updated count.
    assign credit_used   = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
    assign rdata_illegal = (imem_rdata[INSTR_WIDTH-1 -: 2] == 2'b01);

    // Responses arriving while halted belong to requests made after the
    // illegal word and are dropped, so nothing past it gets issued.
    assign push = pending_q && (state_q == RUN) && !redirect_valid;
    assign pop  = issue_valid && issue_ready;

    assign imem_addr = pc_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // FSM next state and fetch enable
    always_comb begin
        state_d = state_q;
        imem_en = 1'b0;
        if (rst_n && (state_q == RUN) && !redirect_valid && (credit_used < DEPTH_C))
            imem_en = 1'b1;
        if (redirect_valid)
            state_d = RUN;
        else if (push && rdata_illegal)
            state_d = HALTED;
    end

    // PC, in-flight tracking and FIFO pointers/occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= '0;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else if (redirect_valid) begin
            pc_q      <= redirect_pc;
            pending_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= imem_en;
            if (imem_en) begin
                pc_q         <= pc_q + PC_ONE;
                pending_pc_q <= pc_q;
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_q <= count_q + CNT_ONE;
            else if (!push && pop) count_q <= count_q - CNT_ONE;
        end
    end

    // FIFO storage; contents only matter under a valid occupancy count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr_q] <= imem_rdata;
            fifo_pc[wr_ptr_q]    <= pending_pc_q;
        end
    end

    assign count         = count_q;
    assign halted        = (state_q == HALTED);
    assign issue_valid   = (count_q != '0);
    assign issue_instr   = issue_valid ? fifo_instr[rd_ptr_q] : '0;
    assign issue_pc      = issue_valid ? fifo_pc[rd_ptr_q] : '0;
    assign issue_opcode  = issue_instr[INSTR_WIDTH-1 -: 3];
    assign issue_illegal = issue_valid && (issue_opcode[2:1] == 2'b01);

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed bench for fetch_issue_unit: a stall/release vector table plus
// hand sequences for ready streaming, redirect, halt and PC wrap.
module tb_fetch_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        issue_valid;
    logic [15:0] issue_instr;
    logic [2:0]  issue_opcode;
    logic [7:0]  issue_pc;
    logic        issue_illegal;
    logic        issue_ready;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        halted;
    logic [2:0]  count;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [15:0] mem [256];

    typedef struct {
        logic       rdy;
        logic       en;
        logic [7:0] addr;
        logic       valid;
        logic [7:0] ipc;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl [16];

    fetch_issue_unit #(.PC_WIDTH(8), .INSTR_WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .issue_valid(issue_valid), .issue_instr(issue_instr),
        .issue_opcode(issue_opcode), .issue_pc(issue_pc),
        .issue_illegal(issue_illegal), .issue_ready(issue_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .count(count)
    );

    always #5 clk = ~clk;

    // 1-cycle latency memory; idle cycles return a poison word
    always @(posedge clk)
        imem_rdata <= imem_en ? mem[imem_addr] : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    // Hold reset one edge, check reset values, then release: the caller
    // is left at the start of cycle 0.
    task automatic do_reset();
        rst_n = 1'b0; issue_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        nxt();
        @(negedge clk);
        chk("rst_en",      {31'b0, imem_en}, 0);
        chk("rst_valid",   {31'b0, issue_valid}, 0);
        chk("rst_count",   {29'b0, count}, 0);
        chk("rst_halted",  {31'b0, halted}, 0);
        chk("rst_illegal", {31'b0, issue_illegal}, 0);
        chk("rst_instr",   {16'b0, issue_instr}, 0);
        chk("rst_pc",      {24'b0, issue_pc}, 0);
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'h00, 8'(i)};

        tbl[0]  = '{1'b0, 1'b1, 8'd0, 1'b0, 8'd0, 3'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'd1, 1'b0, 8'd0, 3'd0};
        tbl[2]  = '{1'b0, 1'b1, 8'd2, 1'b1, 8'd0, 3'd1};
        tbl[3]  = '{1'b0, 1'b1, 8'd3, 1'b1, 8'd0, 3'd2};
        tbl[4]  = '{1'b0, 1'b0, 8'd4, 1'b1, 8'd0, 3'd3};
        tbl[5]  = '{1'b0, 1'b0, 8'd4, 1'b1, 8'd0, 3'd4};
        tbl[6]  = '{1'b0, 1'b0, 8'd4, 1'b1, 8'd0, 3'd4};
        tbl[7]  = '{1'b0, 1'b0, 8'd4, 1'b1, 8'd0, 3'd4};
        tbl[8]  = '{1'b0, 1'b0, 8'd4, 1'b1, 8'd0, 3'd4};
        tbl[9]  = '{1'b0, 1'b0, 8'd4, 1'b1, 8'd0, 3'd4};
        tbl[10] = '{1'b1, 1'b0, 8'd4, 1'b1, 8'd0, 3'd4};
        tbl[11] = '{1'b1, 1'b1, 8'd4, 1'b1, 8'd1, 3'd3};
        tbl[12] = '{1'b1, 1'b1, 8'd5, 1'b1, 8'd2, 3'd2};
        tbl[13] = '{1'b1, 1'b1, 8'd6, 1'b1, 8'd3, 3'd2};
        tbl[14] = '{1'b1, 1'b1, 8'd7, 1'b1, 8'd4, 3'd2};
        tbl[15] = '{1'b1, 1'b1, 8'd8, 1'b1, 8'd5, 3'd2};

        // Stall with ready low, then release; one row per cycle from cycle 0
        do_reset();
        for (int k = 0; k < 16; k++) begin
            issue_ready = tbl[k].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_en", k),    {31'b0, imem_en},     {31'b0, tbl[k].en});
            chk($sformatf("tbl%0d_addr", k),  {24'b0, imem_addr},   {24'b0, tbl[k].addr});
            chk($sformatf("tbl%0d_valid", k), {31'b0, issue_valid}, {31'b0, tbl[k].valid});
            chk($sformatf("tbl%0d_pc", k),    {24'b0, issue_pc},    {24'b0, tbl[k].ipc});
            chk($sformatf("tbl%0d_count", k), {29'b0, count},       {29'b0, tbl[k].cnt});
            if (tbl[k].valid)
                chk($sformatf("tbl%0d_instr", k), {16'b0, issue_instr}, {24'b0, tbl[k].ipc});
            nxt();
        end

        // Ready held high from reset: PCs 0,1,2,... from cycle 2, no gaps
        do_reset();
        issue_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("run%0d_valid", k), {31'b0, issue_valid}, (k >= 2) ? 1 : 0);
            if (k >= 2) begin
                chk($sformatf("run%0d_pc", k), {24'b0, issue_pc}, k - 2);
                chk($sformatf("run%0d_count", k), {29'b0, count}, 1);
            end
            nxt();
        end

        // Redirect to 0x40 with 3 queued entries and one in flight
        do_reset();
        for (int k = 0; k < 4; k++) nxt();
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        @(negedge clk);
        chk("rd_pre_count", {29'b0, count}, 3);
        chk("rd_cyc_en", {31'b0, imem_en}, 0);
        nxt();
        redirect_valid = 1'b0; issue_ready = 1'b1;
        @(negedge clk);
        chk("rd1_count", {29'b0, count}, 0);
        chk("rd1_valid", {31'b0, issue_valid}, 0);
        chk("rd1_en", {31'b0, imem_en}, 1);
        chk("rd1_addr", {24'b0, imem_addr}, 32'h40);
        nxt();
        @(negedge clk);
        chk("rd2_count", {29'b0, count}, 0);
        chk("rd2_addr", {24'b0, imem_addr}, 32'h41);
        nxt();
        @(negedge clk);
        chk("rd3_valid", {31'b0, issue_valid}, 1);
        chk("rd3_pc", {24'b0, issue_pc}, 32'h40);
        chk("rd3_instr", {16'b0, issue_instr}, 32'h0040);
        chk("rd3_count", {29'b0, count}, 1);
        nxt();
        @(negedge clk);
        chk("rd4_pc", {24'b0, issue_pc}, 32'h41);
        nxt();

        // Illegal opcode at PC 5 halts fetch; redirect to 0x10 resumes
        mem[5] = 16'h4005;
        do_reset();
        issue_ready = 1'b1;
        for (int k = 0; k < 7; k++) nxt();
        @(negedge clk);
        chk("ill_valid", {31'b0, issue_valid}, 1);
        chk("ill_pc", {24'b0, issue_pc}, 5);
        chk("ill_opcode", {29'b0, issue_opcode}, 2);
        chk("ill_flag", {31'b0, issue_illegal}, 1);
        chk("ill_halted", {31'b0, halted}, 1);
        chk("ill_en", {31'b0, imem_en}, 0);
        nxt();
        for (int k = 8; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("ill%0d_valid", k), {31'b0, issue_valid}, 0);
            chk($sformatf("ill%0d_en", k), {31'b0, imem_en}, 0);
            chk($sformatf("ill%0d_halted", k), {31'b0, halted}, 1);
            nxt();
        end
        redirect_valid = 1'b1; redirect_pc = 8'h10;
        @(negedge clk);
        chk("ill_rd_en", {31'b0, imem_en}, 0);
        nxt();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("ill_res_halted", {31'b0, halted}, 0);
        chk("ill_res_en", {31'b0, imem_en}, 1);
        chk("ill_res_addr", {24'b0, imem_addr}, 32'h10);
        nxt(); nxt();
        @(negedge clk);
        chk("ill_res_pc", {24'b0, issue_pc}, 32'h10);
        chk("ill_res_valid", {31'b0, issue_valid}, 1);
        nxt();
        mem[5] = 16'h0005;

        // PC wrap: redirect to 0xFE issues FE, FF, 00, 01
        do_reset();
        issue_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'hFE;
        nxt();
        redirect_valid = 1'b0;
        nxt(); nxt();
        for (int k = 0; k < 4; k++) begin
            logic [7:0] exp_pc;
            exp_pc = 8'hFE + 8'(k);
            @(negedge clk);
            chk($sformatf("wrap%0d_valid", k), {31'b0, issue_valid}, 1);
            chk($sformatf("wrap%0d_pc", k), {24'b0, issue_pc}, {24'b0, exp_pc});
            chk($sformatf("wrap%0d_instr", k), {16'b0, issue_instr}, {24'b0, exp_pc});
            nxt();
        end

        // Redirect coinciding with a response and a completed handshake
        do_reset();
        issue_ready = 1'b1;
        for (int k = 0; k < 5; k++) nxt();
        redirect_valid = 1'b1; redirect_pc = 8'h20;
        @(negedge clk);
        chk("same_hs_valid", {31'b0, issue_valid}, 1);
        chk("same_hs_pc", {24'b0, issue_pc}, 3);
        nxt();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("same_count", {29'b0, count}, 0);
        chk("same_valid", {31'b0, issue_valid}, 0);
        chk("same_addr", {24'b0, imem_addr}, 32'h20);
        nxt(); nxt();
        @(negedge clk);
        chk("same_next_pc", {24'b0, issue_pc}, 32'h20);
        chk("same_next_valid", {31'b0, issue_valid}, 1);
        nxt();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_issue_unit.md
# fetch_issue_unit

Instruction fetch and issue stage feeding the decode stage. Generates instruction-memory addresses, captures returned words into a small FIFO, and presents one instruction per cycle (word, 3-bit opcode, PC) to decode under a valid/ready handshake. It is the producer side of the opcode interface consumed by the control decoder. Supports redirect from the branch-resolution stage and halts fetching on an undefined opcode.

## Interface

Parameters:
- `PC_WIDTH`, default 8: word-address width; PC wraps modulo 2^PC_WIDTH.
- `INSTR_WIDTH`, default 16: instruction width; opcode is bits `[INSTR_WIDTH-1 -: 3]`.
- `DEPTH`, default 4: issue FIFO entries; power of two, at least 2.

Ports:
- `clk` in 1: single clock, all state on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `imem_en` out 1: fetch request this cycle.
- `imem_addr` out PC_WIDTH: fetch address, equal to the PC register.
- `imem_rdata` in INSTR_WIDTH: word for the request made in the previous cycle (fixed 1-cycle latency).
- `issue_valid` out 1: FIFO head valid.
- `issue_instr` out INSTR_WIDTH: head instruction.
- `issue_opcode` out 3: head opcode field.
- `issue_pc` out PC_WIDTH: head PC.
- `issue_illegal` out 1: head opcode is 3'b010 or 3'b011.
- `issue_ready` in 1: decode accepts the head; transfer when `issue_valid && issue_ready`.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_pc` in PC_WIDTH: restart address.
- `halted` out 1: fetch stopped on an illegal opcode.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation

- State: PC, FIFO (words and PCs), `pending` flag plus `pending_pc`, and a 2-state FSM, RUN/HALTED.
- `imem_en = RUN && !redirect_valid && (count + pending < DEPTH)`. Credit is not released early on pop.
- Request cycle: `pending <= 1`, `pending_pc <= PC`, `PC <= PC + 1`, wrapping from all-ones to 0.
- Response cycle (`pending == 1`): push `imem_rdata` and `pending_pc`. `pending` clears unless a new request is made in the same cycle.
- If a pushed word's opcode is 010 or 011, the FSM enters HALTED and no further requests are made. The illegal word itself is still queued and issued with `issue_illegal = 1`.
- HALTED exits only on redirect or reset.
- Pop on handshake. Push and pop in the same cycle leave `count` unchanged.
- Branch opcode 110 gets no special handling: fetch proceeds sequentially (predict not-taken).
- Redirect has priority over every other event in the same cycle:
  - FIFO empties; `count <= 0`.
  - The in-flight response is discarded; `pending <= 0`.
  - `PC <= redirect_pc`; FSM goes to RUN; `imem_en = 0` in that cycle.
  - A handshake completing in the redirect cycle still counts as issued. Squashing it is the redirect source's responsibility.
- Reset values:
  - PC = 0, `pending` = 0, `count` = 0, FSM = RUN.
  - `issue_valid` = 0, `halted` = 0, `issue_illegal` = 0.
  - `issue_instr`/`issue_pc` = 0.
  - `imem_en` = 0 while `rst_n` is low.

## Timing

- `issue_*`, `halted` and `count` derive from registers only. There is no combinational path from `issue_ready` or `redirect_valid` to any `issue_*` output.
- `imem_en` is combinational from `redirect_valid` and state.
- Cycle 0 is the first cycle with `rst_n` high:
  - cycle 0: `imem_en = 1`, `imem_addr = 0`
  - cycle 1: data arrives and is pushed
  - cycle 2: `issue_valid = 1`, `issue_pc = 0`
- Fetch-to-issue latency is 2 cycles. Sustained throughput is 1 instruction/cycle with `issue_ready` held high.
- With `issue_ready = 0`: `count` saturates at DEPTH, `imem_en` drops once `count + pending == DEPTH`, and no word is lost or duplicated.
- Redirect in cycle N:
  - cycle N+1: `imem_en = 1`, `imem_addr = redirect_pc`, `issue_valid = 0`
  - cycle N+3: first redirected instruction issued
- Reset mid-operation: all state returns to reset values on the next edge, and any in-flight response is ignored.

## Test plan

- Reset release, memory[i] = {3'b000, i}, `issue_ready = 1` → `issue_pc` runs 0,1,2,… starting at cycle 2, one per cycle, no gaps.
- `issue_ready = 0` for 10 cycles → `count` = 4, `imem_en` = 0 from cycle 4. Release → PCs 0..N issued in order with none skipped.
- Redirect to 0x40 while FIFO holds 3 entries and a request is in flight → `count = 0` next cycle, `imem_addr = 0x40`, next issued PC = 0x40, and no stale word appears.
- Memory[5] opcode = 010 → PC 5 issued with `issue_illegal = 1`, `halted = 1`, `imem_en = 0`, and nothing after PC 5 is issued. Redirect to 0x10 → fetch resumes and `halted = 0`.
- PC_WIDTH = 8, redirect to 0xFE → issued PCs 0xFE, 0xFF, 0x00, 0x01.
- Redirect asserted in the same cycle as a response arrives and a handshake completes → the handshake counts, the response is dropped, and `count = 0` next cycle.
